// File: rtl/war_pkg.sv
// Shared definitions for the packet write arbiter: FSM state encoding,
// header field offsets and arbitration mode constants.
package war_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARB  = 2'd1,
        ST_XFER = 2'd2
    } war_state_e;

    // Header beat layout: destination at the bottom, priority just above.
    localparam int HDR_DES_LSB = 0;

    localparam logic MODE_SP  = 1'b0;
    localparam logic MODE_WRR = 1'b1;

    function automatic int hdr_prio_lsb(input int des_w);
        return HDR_DES_LSB + des_w;
    endfunction

    // A credit counts up to priority+1 packets, so it needs one extra bit.
    function automatic int cred_w(input int prio_w);
        return prio_w + 1;
    endfunction

endpackage

// File: rtl/war_pick.sv
// Combinational winner selection for the packet write arbiter.
// Ports: req (per-port request), prio (packed header priorities) -> win.
// With WAR_WRR_EN defined it also takes mode, credit and ptr, and returns
// reload plus the effective (possibly reloaded) credits.
module war_pick
    import war_pkg::*;
#(
    parameter int NUM_PORTS = 16,
    parameter int PRIO_W    = 3,
    parameter int GW        = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0]        req,
    input  logic [NUM_PORTS*PRIO_W-1:0] prio,
    output logic [GW-1:0]               win
`ifdef WAR_WRR_EN
    ,
    input  logic                                 mode,
    input  logic [NUM_PORTS*cred_w(PRIO_W)-1:0]  credit,
    input  logic [GW-1:0]                        ptr,
    output logic                                 reload,
    output logic [NUM_PORTS*cred_w(PRIO_W)-1:0]  credit_eff
`endif
);

    logic [GW-1:0]     win_sp;
    logic [PRIO_W-1:0] best;
    logic              hit;

    // Strict '>' keeps the lowest index on equal priority.
    always_comb begin
        win_sp = '0;
        best   = '0;
        hit    = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (req[i] &&
                (!hit || prio[i*PRIO_W +: PRIO_W] > best)) begin
                hit    = 1'b1;
                best   = prio[i*PRIO_W +: PRIO_W];
                win_sp = GW'(i);
            end
        end
    end

`ifdef WAR_WRR_EN
    localparam int CW = cred_w(PRIO_W);

    logic [NUM_PORTS-1:0] has_cr;
    logic [NUM_PORTS-1:0] elig;
    logic [GW-1:0]        win_rr;
    logic                 hit_rr;

    always_comb begin
        has_cr = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            has_cr[i] = credit[i*CW +: CW] != '0;
        end
    end

    // Reload when no requester has credit left; the reloaded values
    // feed the scan directly so the grant lands in the same cycle.
    assign reload = ~|(req & has_cr);

    // Only requesting ports carry a valid header, so idle ports reload
    // to zero and join at the next reload after they start requesting.
    always_comb begin
        credit_eff = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (reload) begin
                credit_eff[i*CW +: CW] = req[i] ?
                    CW'(prio[i*PRIO_W +: PRIO_W]) + CW'(1) : '0;
            end else begin
                credit_eff[i*CW +: CW] = credit[i*CW +: CW];
            end
        end
    end

    always_comb begin
        elig = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            elig[i] = req[i] & (credit_eff[i*CW +: CW] != '0);
        end
    end

    // First eligible port at or after the round-robin pointer.
    always_comb begin
        win_rr = '0;
        hit_rr = 1'b0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (!hit_rr && elig[(int'(ptr) + k) % NUM_PORTS]) begin
                hit_rr = 1'b1;
                win_rr = GW'((int'(ptr) + k) % NUM_PORTS);
            end
        end
    end

    assign win = (mode == MODE_WRR) ? win_rr : win_sp;
`else
    assign win = win_sp;
`endif

endmodule

// File: rtl/pkt_write_arbiter.sv
// Packet write arbiter: grants one of NUM_PORTS packet sources from sop to
// eop and forwards its beats through a registered output stage.
// Ports: clk, rst (async active-low), sp0_wrr1 (0 SP / 1 WRR),
//   vld/sop/eop/data_in_p (per-port beats), next_data (per-port accept),
//   out_ready, out_vld/out_sop/out_eop/out_data (output beat),
//   out_des_port, grant_idx, busy.
// Define WAR_WRR_EN to build the weighted round-robin path; without it the
// arbiter is strict-priority only and sp0_wrr1 is ignored.
module pkt_write_arbiter
    import war_pkg::*;
#(
    parameter int NUM_PORTS = 16,
    parameter int DATA_W    = 64,
    parameter int PRIO_W    = 3,
    parameter int DES_W     = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          sp0_wrr1,
    input  logic [NUM_PORTS-1:0]          vld,
    input  logic [NUM_PORTS-1:0]          sop,
    input  logic [NUM_PORTS-1:0]          eop,
    input  logic [NUM_PORTS*DATA_W-1:0]   data_in_p,
    output logic [NUM_PORTS-1:0]          next_data,
    input  logic                          out_ready,
    output logic                          out_vld,
    output logic                          out_sop,
    output logic                          out_eop,
    output logic [DATA_W-1:0]             out_data,
    output logic [DES_W-1:0]              out_des_port,
    output logic [$clog2(NUM_PORTS)-1:0]  grant_idx,
    output logic                          busy
);

    localparam int GW   = $clog2(NUM_PORTS);
    localparam int PLSB = hdr_prio_lsb(DES_W);

    war_state_e                  state;
    logic [NUM_PORTS-1:0]        req;
    logic [NUM_PORTS-1:0]        gmask;
    logic [NUM_PORTS*PRIO_W-1:0] prio;
    logic [GW-1:0]               win;
    logic [DES_W-1:0]            win_des;
    logic [DATA_W-1:0]           g_data;
    logic                        take;
    logic                        take_eop;
    logic                        other_req;

    assign req   = vld & sop;
    assign gmask = {{(NUM_PORTS-1){1'b0}}, 1'b1} << grant_idx;

    always_comb begin
        prio = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            prio[i*PRIO_W +: PRIO_W] =
                data_in_p[i*DATA_W + PLSB +: PRIO_W];
        end
    end

    assign win_des = data_in_p[int'(win)*DATA_W + HDR_DES_LSB +: DES_W];
    assign g_data  = data_in_p[int'(grant_idx)*DATA_W +: DATA_W];

    // A beat moves when the granted source has one and the output
    // register is empty or draining this cycle.
    assign take      = (state == ST_XFER) & vld[grant_idx] &
                       (out_ready | ~out_vld);
    assign next_data = take ? gmask : '0;
    assign take_eop  = take & eop[grant_idx];

    // The granted port's own sop on its closing beat is not a new request.
    assign other_req = |(req & ~gmask);

    assign busy = (state != ST_IDLE);

`ifdef WAR_WRR_EN
    localparam int CW = cred_w(PRIO_W);

    logic                    mode_q;
    logic [NUM_PORTS*CW-1:0] credit_q;
    logic [NUM_PORTS*CW-1:0] credit_eff;
    logic [GW-1:0]           ptr_q;
    logic [GW-1:0]           nxt_ptr;
    logic                    reload;

    assign nxt_ptr = (grant_idx == GW'(NUM_PORTS - 1)) ?
                     '0 : grant_idx + GW'(1);

    war_pick #(
        .NUM_PORTS (NUM_PORTS),
        .PRIO_W    (PRIO_W),
        .GW        (GW)
    ) u_pick (
        .req        (req),
        .prio       (prio),
        .win        (win),
        .mode       (sp0_wrr1),
        .credit     (credit_q),
        .ptr        (ptr_q),
        .reload     (reload),
        .credit_eff (credit_eff)
    );
`else
    logic unused_mode;
    assign unused_mode = sp0_wrr1;

    war_pick #(
        .NUM_PORTS (NUM_PORTS),
        .PRIO_W    (PRIO_W),
        .GW        (GW)
    ) u_pick (
        .req  (req),
        .prio (prio),
        .win  (win)
    );
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_IDLE;
            grant_idx    <= '0;
            out_des_port <= '0;
            out_vld      <= 1'b0;
            out_sop      <= 1'b0;
            out_eop      <= 1'b0;
            out_data     <= '0;
`ifdef WAR_WRR_EN
            mode_q       <= MODE_SP;
            credit_q     <= '0;
            ptr_q        <= '0;
`endif
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (|req) state <= ST_ARB;
                end
                ST_ARB: begin
                    grant_idx    <= win;
                    out_des_port <= win_des;
                    state        <= ST_XFER;
`ifdef WAR_WRR_EN
                    mode_q <= sp0_wrr1;
                    if (sp0_wrr1 == MODE_WRR && reload) begin
                        credit_q <= credit_eff;
                    end
`endif
                end
                ST_XFER: begin
                    if (take_eop) begin
                        state <= other_req ? ST_ARB : ST_IDLE;
`ifdef WAR_WRR_EN
                        if (mode_q == MODE_WRR) begin
                            if (credit_q[int'(grant_idx)*CW +: CW] != '0) begin
                                credit_q[int'(grant_idx)*CW +: CW] <=
                                    credit_q[int'(grant_idx)*CW +: CW] - CW'(1);
                            end
                            ptr_q <= nxt_ptr;
                        end
`endif
                    end
                end
                default: state <= ST_IDLE;
            endcase

            if (take) begin
                out_vld  <= 1'b1;
                out_sop  <= sop[grant_idx];
                out_eop  <= eop[grant_idx];
                out_data <= g_data;
            end else if (out_ready) begin
                out_vld  <= 1'b0;
            end
        end
    end

endmodule
